// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared definitions for the multi-port register file.
//   - default data width and register count
//   - zero constant used for gated read data
//   - clear-sequencer state encodings
//   - packed-port slice helper macro
// Optional build macro used by regfile_mp: REGFILE_MP_DIFFTEST_EN.

`ifndef REGFILE_MP_PKG_DEFS
`define REGFILE_MP_PKG_DEFS
// Select element idx of width w from a flat packed vector.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package regfile_mp_pkg;

  localparam int unsigned RF_XLEN_DEF = 64;
  localparam int unsigned RF_NREG_DEF = 32;

  localparam logic [RF_XLEN_DEF-1:0] RF_ZERO = '0;

  // Clear sequencer states
  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_RUN   = 1'b1;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: zeroes the register file one entry per cycle after reset.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   ready    out  high once every entry has been cleared (state RUN)
//   clr_we   out  clear write strobe for the storage
//   clr_addr out  entry being cleared this cycle

module regfile_clear_ctrl
  import regfile_mp_pkg::*;
#(
  parameter  int unsigned NREG = RF_NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREG - 1)) begin
        state_d = RF_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = (state_q == RF_RUN);
  assign clr_we   = !rst && (state_q == RF_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   Storage is zeroed by a clear sequencer after reset; reads are
//   combinational with per-port write-to-read bypass; simultaneous writes to
//   one address resolve to the highest-index write port. Entry 0 reads as 0.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   ready    out  high once the clear sequence has completed
//   rd_en    in   [NRD]        per-read-port enable
//   rd_addr  in   [NRD*AW]     read addresses, port i at [i*AW +: AW]
//   rd_data  out  [NRD*XLEN]   read data, port i at [i*XLEN +: XLEN]
//   wr_en    in   [NWR]        per-write-port enable
//   wr_addr  in   [NWR*AW]     write addresses
//   wr_data  in   [NWR*XLEN]   write data
//   dbg_regs out  [NREG*XLEN]  storage snapshot (only with REGFILE_MP_DIFFTEST_EN)

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int unsigned XLEN = RF_XLEN_DEF,
  parameter  int unsigned NREG = RF_NREG_DEF,
  parameter  int unsigned NRD  = 2,
  parameter  int unsigned NWR  = 1,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data
`ifdef REGFILE_MP_DIFFTEST_EN
  ,
  output logic [NREG*XLEN-1:0] dbg_regs
`endif
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          run_en;

  regfile_clear_ctrl #(
    .NREG (NREG)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Normal writes and reads are live only in RUN and outside reset.
  assign run_en = ready && !rst;

  // Entry 0 has no storage.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];

  always_comb begin
    regs_d = regs_q;
    for (int unsigned e = 1; e < NREG; e++) begin
      if (clr_we) begin
        if (clr_addr == AW'(e)) begin
          regs_d[e] = '0;
        end
      end else if (run_en) begin
        // Ascending port order: the highest-index matching port wins.
        for (int unsigned p = 0; p < NWR; p++) begin
          if (wr_en[p] && (`RF_SLICE(wr_addr, p, AW) == AW'(e))) begin
            regs_d[e] = `RF_SLICE(wr_data, p, XLEN);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = `RF_SLICE(rd_addr, i, AW);

    always_comb begin
      rv = XLEN'(RF_ZERO);
      if (run_en && rd_en[i] && (ra != '0)) begin
        rv = regs_q[ra];
        // Nonzero ra means a matching write address is nonzero as well.
        for (int unsigned p = 0; p < NWR; p++) begin
          if (wr_en[p] && (`RF_SLICE(wr_addr, p, AW) == ra)) begin
            rv = `RF_SLICE(wr_data, p, XLEN);
          end
        end
      end
    end

    assign `RF_SLICE(rd_data, i, XLEN) = rv;
  end

`ifdef REGFILE_MP_DIFFTEST_EN
  assign dbg_regs[0 +: XLEN] = '0;
  for (genvar k = 1; k < NREG; k++) begin : g_dbg
    assign dbg_regs[k*XLEN +: XLEN] = regs_q[k];
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XL = 64;
  localparam int NR = 32;
  localparam int A  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [1:0]      rd_en;
  logic [2*A-1:0]  rd_addr;
  logic [2*XL-1:0] rd_data;
  logic [1:0]      wr_en;
  logic [2*A-1:0]  wr_addr;
  logic [2*XL-1:0] wr_data;
`ifdef REGFILE_MP_DIFFTEST_EN
  logic [NR*XL-1:0] dbg_regs;
`endif

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN (XL),
    .NREG (NR),
    .NRD  (2),
    .NWR  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`ifdef REGFILE_MP_DIFFTEST_EN
    ,
    .dbg_regs (dbg_regs)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model of the specified behaviour
  logic [63:0] mregs [NR];
  bit          mrun = 1'b0;
  int          mcnt = 0;

  function automatic logic [63:0] exp_read(input int i);
    logic [A-1:0] a;
    logic [63:0]  r;
    if (rst || !mrun || !rd_en[i]) return 64'd0;
    a = rd_addr[i*A +: A];
    if (a == 0) return 64'd0;
    r = mregs[a];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*A +: A] == a) r = wr_data[p*XL +: XL];
    return r;
  endfunction

  task automatic model_edge();
    if (rst) begin
      mrun = 1'b0;
      mcnt = 0;
    end else if (!mrun) begin
      mregs[mcnt] = 64'd0;
      if (mcnt == NR - 1) mrun = 1'b1;
      mcnt = (mcnt + 1) % NR;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*A +: A] != 0)
          mregs[wr_addr[p*A +: A]] = wr_data[p*XL +: XL];
    end
  endtask

  typedef struct {
    string       tag;
    int          port;
    logic [63:0] exp;
  } sb_t;
  sb_t sb[$];

  // One cycle: expectations queued for the driven inputs, compared at the
  // falling edge, then the model advances with the DUT on the rising edge.
  task automatic step(input string name);
    sb.push_back('{tag: {name, "/rd0"},  port: 0, exp: exp_read(0)});
    sb.push_back('{tag: {name, "/rd1"},  port: 1, exp: exp_read(1)});
    sb.push_back('{tag: {name, "/rdy"},  port: 2, exp: {63'd0, mrun}});
    @(negedge clk);
    while (sb.size() > 0) begin
      sb_t e;
      logic [63:0] got;
      e = sb.pop_front();
      if (e.port == 2) got = {63'd0, ready};
      else             got = rd_data[e.port*XL +: XL];
      check(e.tag, got, e.exp);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input int i, input logic en, input int addr);
    rd_en[i] = en;
    rd_addr[i*A +: A] = A'(addr);
  endtask

  task automatic set_wr(input int p, input logic en, input int addr, input logic [63:0] d);
    wr_en[p] = en;
    wr_addr[p*A +: A] = A'(addr);
    wr_data[p*XL +: XL] = d;
  endtask

  initial begin
    int edges;
    logic [63:0] x3v;
    rst = 1'b1;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < NR; k++) mregs[k] = 'x;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held: outputs zero even with enabled reads
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 9);
    for (int k = 0; k < 3; k++) step("rst");
    rst = 1'b0;

    // Partial clear with writes attempted (dropped, not bypassed)
    set_wr(0, 1'b1, 5, 64'h1234);
    set_wr(1, 1'b1, 9, 64'h5678);
    for (int k = 0; k < 10; k++) step("clr1");
    rst = 1'b1;
    step("rst2");
    rst = 1'b0;

    edges = 0;
    for (int k = 0; k < 100; k++) begin
      step("clr2");
      edges++;
      if (ready === 1'b1) break;
    end
    check("clr_len", 64'(edges), 64'd32);
    set_wr(0, 1'b0, 0, 64'd0);
    set_wr(1, 1'b0, 0, 64'd0);

    // Every entry is zero after the clear
    for (int k = 0; k < NR / 2; k++) begin
      set_rd(0, 1'b1, 2 * k);
      set_rd(1, 1'b1, 2 * k + 1);
      step("zero");
    end

    // Basic write with same-cycle bypass, then from storage, then rd_en=0
    set_wr(0, 1'b1, 5, 64'hDEAD_BEEF_0000_0001);
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 6);
    step("wr5_byp");
    check("wr5_byp_k", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    set_wr(0, 1'b0, 5, 64'hAAAA_AAAA_AAAA_AAAA);
    step("wr5_mem");
    set_rd(0, 1'b0, 5);
    step("wr5_off");

    // x0 rule
    set_wr(0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_rd(0, 1'b1, 0);
    set_rd(1, 1'b1, 0);
    step("x0_byp");
    set_wr(0, 1'b0, 0, 64'd0);
    step("x0_mem");

    // Write-write conflict: port 1 wins
    set_wr(0, 1'b1, 7, 64'h1);
    set_wr(1, 1'b1, 7, 64'h2);
    set_rd(0, 1'b1, 7);
    set_rd(1, 1'b1, 7);
    step("conf_byp");
    set_wr(0, 1'b0, 0, 64'd0);
    set_wr(1, 1'b0, 0, 64'd0);
    step("conf_mem");
    check("conf_mem_k", rd_data[127:64], 64'h2);

    // Dual-port independence
    x3v = 64'h3333_0000_3333_0003;
    set_wr(0, 1'b1, 3, x3v);
    step("x3_wr");
    set_wr(0, 1'b0, 0, 64'd0);
    set_wr(1, 1'b1, 4, 64'h44);
    set_rd(0, 1'b1, 3);
    set_rd(1, 1'b1, 4);
    step("dual");

    // Address match without wr_en reads storage
    set_wr(1, 1'b0, 3, 64'hBAD0_BAD0_BAD0_BAD0);
    step("noen");

    // Randomised traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) set_rd(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      for (int p = 0; p < 2; p++) set_wr(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom});
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
